// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU clock controller: controller states and
// instruction-phase constants.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    HALT  = 2'd0,
    RUN   = 2'd1,
    STEP  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam logic [1:0] LAST_PHASE = 2'd3;

endpackage

// File: rtl/clk_divider.sv
// Programmable clock-enable divider: tick fires once every div+1 enabled
// cycles; the count is held at zero while disabled.
module clk_divider #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // A comparison of >= lets a lowered div take effect at once without
  // waiting for the counter to wrap.
  always_comb begin
    tick  = en && (cnt_q >= div);
    cnt_d = cnt_q;
    if (!en || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cpu_clock_ctrl.sv
// CPU clock controller: free-run, single-step, drain-to-boundary and
// breakpoint control of a four-phase processor via a divided clock enable.
module cpu_clock_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned DIV_W = 8,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             halt,
  input  logic             step,
  input  logic [DIV_W-1:0] div,
  input  logic [15:0]      pc,
  input  logic             bp_en,
  input  logic [15:0]      bp_addr,
  input  logic             halt_insn,
  output logic             cpu_en,
  output logic [1:0]       phase,
  output logic             instr_done,
  output logic             running,
  output logic             stopped_bp,
  output logic [CNT_W-1:0] cyc_cnt
);

  state_e           state_q;
  logic [1:0]       phase_q;
  logic             stopped_bp_q;
  logic [CNT_W-1:0] cyc_cnt_q;
  logic             first_q;
  logic             tick;
  logic             bp_hit;

  clk_divider #(
    .DIV_W(DIV_W)
  ) u_div (
    .clk  (clk),
    .reset(reset),
    .en   (state_q != HALT),
    .div  (div),
    .tick (tick)
  );

  // The breakpoint must veto the very tick that would start the instruction,
  // so the enable path is combinational from the divider and pc compare.
  always_comb begin
    bp_hit     = tick && (state_q == RUN) && (phase_q == 2'd0) && bp_en &&
                 (pc == bp_addr) && !first_q;
    cpu_en     = tick && !bp_hit;
    instr_done = cpu_en && (phase_q == LAST_PHASE);
    running    = (state_q != HALT);
    phase      = phase_q;
    stopped_bp = stopped_bp_q;
    cyc_cnt    = cyc_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= HALT;
      phase_q      <= '0;
      stopped_bp_q <= 1'b0;
      cyc_cnt_q    <= '0;
      first_q      <= 1'b0;
    end else begin
      if (cpu_en) begin
        phase_q   <= phase_q + 2'd1;
        cyc_cnt_q <= cyc_cnt_q + 1'b1;
      end
      if (instr_done) begin
        first_q <= 1'b0;
      end
      unique case (state_q)
        HALT: begin
          if (!halt && step) begin
            state_q      <= STEP;
            stopped_bp_q <= 1'b0;
            first_q      <= 1'b1;
          end else if (!halt && run) begin
            state_q      <= RUN;
            stopped_bp_q <= 1'b0;
            first_q      <= 1'b1;
          end
        end
        RUN: begin
          // A halt landing exactly on a boundary stops there rather than
          // draining a whole further instruction.
          if (bp_hit) begin
            state_q      <= HALT;
            stopped_bp_q <= 1'b1;
          end else if (instr_done && (halt_insn || halt)) begin
            state_q <= HALT;
          end else if (halt) begin
            state_q <= DRAIN;
          end
        end
        STEP: begin
          if (instr_done) begin
            state_q <= HALT;
          end else if (halt) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (instr_done) begin
            state_q <= HALT;
          end
        end
        default: state_q <= HALT;
      endcase
    end
  end

endmodule
